e_mdu: RTL and testbench
========================

# e_mdu

Multiply/divide unit in the E stage of the five-stage pipeline, alongside the ALU, one stage upstream of M-stage data memory. It owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations under a busy/done handshake, and MTHI/MTLO/MFHI/MFLO in a single cycle. MF results are muxed with the ALU result into the E/M register that supplies the data-memory address and write data.

## Interface
- MULT_CYCLES, 5: busy cycles for MULT/MULTU/MADD/MADDU.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low.
- start  in  1  issue strobe, qualified by mdu_op; hazard unit drives it only from an unstalled E stage.
- mdu_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; others NONE.
- rs_data  in  32  operand A (dividend / MT source).
- rt_data  in  32  operand B (divisor).
- busy  out  1  high while a multi-cycle op is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- mf_data  out  32  combinational: HI when mdu_op==MFHI, LO otherwise.
- hi_out, lo_out  out  32  current HI/LO register values.

## Operation
- States: IDLE, RUN. Counter cnt of width clog2(DIV_CYCLES+1).
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU,MADD*}: latch op, rs_data, rt_data; load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN: cnt decrements each cycle. At the edge where cnt==1, HI/LO commit, busy clears, done pulses next cycle, and the state returns to IDLE.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder, sign of dividend. DIVU: unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- Divide by zero (either signedness): runs full DIV_CYCLES; HI/LO unchanged; done still pulses.
- MTHI/MTLO with start=1 in IDLE: write rs_data at that edge. No busy, no done.
- MFHI/MFLO: no state change. mf_data reflects the registers as of the current cycle.
- start while busy: ignored entirely. Any op, including MT, writes nothing. The hazard unit must stall; the bench checks the ignore.
- start with NONE or MF op: no state change.

## Timing
- Reset (reset==0 at posedge): state IDLE, cnt 0, busy 0, done 0, HI 0, LO 0, latched operands 0. Any op in flight is discarded without commit. Reset dominates start.
- Issue at edge t0 → busy=1 for cycles t0+1 … t0+N (N = MULT_CYCLES/DIV_CYCLES).
- HI/LO update at edge t0+N. busy=0 and done=1 in cycle t0+N+1.
- Back-to-back issue: start accepted in the first cycle busy reads 0.
- MT latency: HI/LO visible the cycle after the write edge. MF after MT in the next instruction reads the new value.

## Configuration
- MDU_MADD_EN defined: opcodes 9/10 accumulate, {HI,LO} += signed/unsigned rs*rt, mod 2^64, using MULT_CYCLES.
- MDU_MADD_EN undefined: opcodes 9/10 decode as NONE; start with them is ignored.

## Structure
- Shared package mdu_pkg: mdu_op encodings, state enum (IDLE, RUN), default cycle-count constants. The decoder in the control unit uses the same encodings.
- Sub-module e_mdu_arith: combinational. Takes latched op/operands and current HI/LO; produces next {HI,LO} and a div-by-zero flag. e_mdu holds the FSM, counter and registers.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3 → busy cycles 1–5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands → LO=0x7FFFFFFC, HI=1.
- DIV 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU by 0 with HI=0x11, LO=0x22 preset → unchanged after 10 cycles.
- MTHI 0xDEADBEEF, then MFHI next cycle → mf_data=0xDEADBEEF. MTLO issued while busy → LO unchanged.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, reset low at busy cycle 3 → next cycle busy=0, HI=LO=0, no done pulse.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0. Without the macro → no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU opcode encodings, FSM states and default latencies.
// MDU_MADD_EN enables the MADD/MADDU accumulate opcodes.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op == OP_MULT || op == OP_MULTU ||
               op == OP_MADD || op == OP_MADDU;
`else
        return op == OP_MULT || op == OP_MULTU;
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: next {HI,LO} from latched op/operands.
// MDU_MADD_EN adds the 64-bit multiply-accumulate paths.
module e_mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt,
    output logic        div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        bd;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;

    assign prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign div_zero = is_div(op) && (b == 32'd0);
    // Divisor forced nonzero so the divider never sees x/0.
    assign bd       = (b == 32'd0) ? 32'd1 : b;
    assign sa       = a;
    assign sb       = bd;
    assign ovf      = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        unique case (op)
            OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
            OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
            OP_DIV: begin
                if (ovf) begin
                    lo_nxt = 32'h8000_0000;
                    hi_nxt = 32'd0;
                end else begin
                    lo_nxt = sa / sb;
                    hi_nxt = sa % sb;
                end
            end
            OP_DIVU: begin
                lo_nxt = a / bd;
                hi_nxt = a % bd;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_nxt, lo_nxt} = {hi, lo} + prod_s;
            OP_MADDU: {hi_nxt, lo_nxt} = {hi, lo} + prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; busy/done handshake.
// MDU_MADD_EN enables MADD/MADDU (decoded in mdu_pkg helpers).
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] mf_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    mdu_state_e  state;
    logic [CW-1:0] cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic        div_zero;

    e_mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            op_q  <= OP_NONE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul(mdu_op) || is_div(mdu_op)) begin
                            op_q  <= mdu_op;
                            a_q   <= rs_data;
                            b_q   <= rt_data;
                            cnt   <= is_mul(mdu_op) ? CW'(MULT_CYCLES)
                                                    : CW'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (mdu_op == OP_MTHI) begin
                            hi_q <= rs_data;
                        end else if (mdu_op == OP_MTLO) begin
                            lo_q <= rs_data;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Divide by zero still completes, but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi_q <= hi_nxt;
                            lo_q <= lo_nxt;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mf_data = (mdu_op == OP_MFHI) ? hi_q : lo_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu; define MDU_MADD_EN to cover MADD/MADDU.
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] mf_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    e_mdu dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .mf_data (mf_data),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        mdu_op  = op;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        mdu_op = OP_NONE;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        issue(OP_MTHI, h, 32'd0);
        issue(OP_MTLO, l, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int n, input int k0);
        int k;
        k = k0;
        while (busy && k < 100) begin
            k++;
            tick();
        end
        check({tag, "_busy_len"}, 64'(k), 64'(n));
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() > 0)
            check({tag, "_result"}, {hi_out, lo_out}, sb.pop_front());
        else
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int n);
        sb.push_back(exp);
        issue(op, a, b);
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        wait_done(tag, n, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        int          pulses;

        reset   = 1'b0;
        start   = 1'b0;
        mdu_op  = OP_NONE;
        rs_data = 32'd0;
        rt_data = 32'd0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        reset = 1'b1;
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 5);
        tick();
        check("mult_done_once", 64'(done), 64'd0);

        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 10);
        run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2,
               64'h0000_0001_7FFF_FFFC, 10);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 10);

        set_hilo(32'h11, 32'h22);
        check("mt_no_busy", 64'(busy), 64'd0);
        check("mt_hilo", {hi_out, lo_out}, 64'h0000_0011_0000_0022);
        run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0,
               64'h0000_0011_0000_0022, 10);

        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        mdu_op = OP_MFHI;
        start  = 1'b1;
        #1;
        check("mfhi", 64'(mf_data), 64'hDEAD_BEEF);
        mdu_op = OP_MFLO;
        #1;
        check("mflo", 64'(mf_data), 64'h22);
        tick();
        start  = 1'b0;
        mdu_op = OP_NONE;
        check("mf_no_change", {hi_out, lo_out}, 64'hDEAD_BEEF_0000_0022);

        set_hilo(32'h0, 32'h55);
        sb.push_back(64'd6);
        issue(OP_MULT, 32'd2, 32'd3);
        tick();
        mdu_op  = OP_MTLO;
        rs_data = 32'hBAD;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        mdu_op = OP_NONE;
        check("mt_busy_lo", 64'(lo_out), 64'h55);
        wait_done("mt_busy", 5, 2);

        set_hilo(32'h33, 32'h44);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        check("rst_mid_no_done", 64'(pulses), 64'd0);

`ifdef MDU_MADD_EN
        set_hilo(32'h0, 32'hFFFF_FFFF);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5);
        set_hilo(32'h0, 32'h5);
        run_op("madd", OP_MADD, 32'hFFFF_FFFF, 32'd2,
               64'h0000_0000_0000_0003, 5);
`else
        set_hilo(32'h0, 32'hFFFF_FFFF);
        issue(OP_MADDU, 32'd1, 32'd1);
        check("maddu_off_busy", 64'(busy), 64'd0);
        tick();
        check("maddu_off_done", 64'(done), 64'd0);
        check("maddu_off_hilo", {hi_out, lo_out}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd7;
            sa  = $signed(a);
            sbv = $signed(b);
            case (i % 4)
                0: begin
                    exp = 64'(sa * sbv);
                    run_op("rnd_mult", OP_MULT, a, b, exp, 5);
                end
                1: begin
                    exp = {32'd0, a} * {32'd0, b};
                    run_op("rnd_multu", OP_MULTU, a, b, exp, 5);
                end
                2: begin
                    q = sa / sbv;
                    r = sa % sbv;
                    exp = {r[31:0], q[31:0]};
                    run_op("rnd_div", OP_DIV, a, b, exp, 10);
                end
                default: begin
                    exp = {a % b, a / b};
                    run_op("rnd_divu", OP_DIVU, a, b, exp, 10);
                end
            endcase
        end

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
